// File: rtl/mux_scan_reg_if.sv
// Channel-mux bus: packed channel data and controls in, selected data and status out.
// Pure wiring; the mux itself adds one clock of latency.
// No backpressure; the consumer samples o_y whenever o_y_valid is set.
interface mux_scan_reg_if #(
    parameter int W  = 2,
    parameter int CH = 4,
    parameter int SW = 2
);
    logic [CH*W-1:0] i_din;
    logic [SW-1:0]   i_sel;
    logic            i_en;
    logic            i_mode;
    logic [W-1:0]    o_y;
    logic [SW-1:0]   o_y_ch;
    logic            o_y_valid;
    logic            o_scan_wrap;

    // Source side: drives data and controls, observes the registered result.
    modport master (
        output i_din, i_sel, i_en, i_mode,
        input  o_y, o_y_ch, o_y_valid, o_scan_wrap
    );

    // Mux side.
    modport slave (
        input  i_din, i_sel, i_en, i_mode,
        output o_y, o_y_ch, o_y_valid, o_scan_wrap
    );
endinterface

// File: rtl/mux_scan_reg.sv
// Registered CH:1 mux of W-bit channels, manual select or round-robin auto-scan (DWELL clocks per channel).
// Latency: 1 clock from din/sel/en/mode to y/y_ch/y_valid; scan_wrap pulses on the CH-1 -> 0 index step.
// No backpressure; en=0 freezes the scan and blanks the output (holds it when MUX_SCAN_HOLD_EN is defined).
module mux_scan_reg #(
    parameter int W     = 2,
    parameter int CH    = 4,
    parameter int SW    = 2,
    parameter int DWELL = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    mux_scan_reg_if.slave  bus
);

    // Dwell counter needs at least one bit even when every channel is held a single clock.
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [W-1:0]  r_y;
    logic [SW-1:0] r_y_ch;
    logic          r_y_valid;
    logic          r_scan_wrap;
    logic [SW-1:0] r_scan_idx;
    logic [CW-1:0] r_dwell_cnt;

    logic [W-1:0]  w_man_dat;
    logic [W-1:0]  w_scan_dat;
    logic          w_sel_ok;
    logic          w_dwell_end;
    logic          w_idx_last;

    // Channel extraction by comparison loop, so an out-of-range sel (CH not a power of 2) yields 0 instead of an out-of-bounds slice.
    always_comb begin
        w_man_dat  = '0;
        w_scan_dat = '0;
        for (int k = 0; k < CH; k++) begin
            if (bus.i_sel == SW'(k))
                w_man_dat = bus.i_din[k*W +: W];
            if (r_scan_idx == SW'(k))
                w_scan_dat = bus.i_din[k*W +: W];
        end
    end

    assign w_sel_ok    = (int'(bus.i_sel) < CH);
    assign w_dwell_end = (r_dwell_cnt == CW'(DWELL - 1));
    assign w_idx_last  = (r_scan_idx == SW'(CH - 1));

    // Output and scan-state update: disabled freeze, manual select (reloads scan state), or auto-scan step.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_y         <= '0;
            r_y_ch      <= '0;
            r_y_valid   <= 1'b0;
            r_scan_wrap <= 1'b0;
            r_scan_idx  <= '0;
            r_dwell_cnt <= '0;
        end else if (!bus.i_en) begin
`ifdef MUX_SCAN_HOLD_EN
            // y and y_valid keep the last shown channel while disabled.
`else
            r_y       <= '0;
            r_y_valid <= 1'b0;
`endif
            r_scan_wrap <= 1'b0;
        end else if (!bus.i_mode) begin
            r_scan_wrap <= 1'b0;
            r_dwell_cnt <= '0;
            if (w_sel_ok) begin
                r_y        <= w_man_dat;
                r_y_ch     <= bus.i_sel;
                r_y_valid  <= 1'b1;
                r_scan_idx <= bus.i_sel;
            end else begin
                // Nonexistent channel: blank, keep the last valid y_ch.
                r_y        <= '0;
                r_y_valid  <= 1'b0;
                r_scan_idx <= '0;
            end
        end else begin
            r_y       <= w_scan_dat;
            r_y_ch    <= r_scan_idx;
            r_y_valid <= 1'b1;
            if (w_dwell_end) begin
                r_dwell_cnt <= '0;
                r_scan_idx  <= w_idx_last ? '0 : r_scan_idx + 1'b1;
                r_scan_wrap <= w_idx_last;
            end else begin
                r_dwell_cnt <= r_dwell_cnt + 1'b1;
                r_scan_wrap <= 1'b0;
            end
        end
    end

    assign bus.o_y         = r_y;
    assign bus.o_y_ch      = r_y_ch;
    assign bus.o_y_valid   = r_y_valid;
    assign bus.o_scan_wrap = r_scan_wrap;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Bench for mux_scan_reg with default parameters (W=2, CH=4, SW=2, DWELL=4).
// Expected outputs are pushed to a queue when inputs are driven and popped one clock later.
// Expectations for the disabled state follow MUX_SCAN_HOLD_EN, matching the RTL build.
module tb_mux_scan_reg;

    typedef struct packed {
        logic [1:0] y;
        logic [1:0] ch;
        logic       vld;
        logic       wrap;
    } exp_t;

    localparam logic [7:0] DIN_DEF = 8'b11_10_01_00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t got;
    exp_t exp_v;

    mux_scan_reg_if #(.W(2), .CH(4), .SW(2)) bus ();

    mux_scan_reg #(.W(2), .CH(4), .SW(2), .DWELL(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign got = '{y: bus.o_y, ch: bus.o_y_ch, vld: bus.o_y_valid, wrap: bus.o_scan_wrap};

    function automatic exp_t mk(input int y, input int ch, input bit vld, input bit wrap);
        mk = '{y: 2'(y), ch: 2'(ch), vld: vld, wrap: wrap};
    endfunction

    task automatic test_reset();
        bus.i_din  = DIN_DEF;
        bus.i_sel  = 2'd2;
        bus.i_en   = 1'b0;
        bus.i_mode = 1'b0;
        rst        = 1'b1;
        #12;
        checks++;
        if (got !== mk(0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_state got=%b exp=%b", got, mk(0, 0, 0, 0));
        end
        @(negedge clk);
        rst = 1'b0;
        sb.push_back(mk(0, 0, 0, 0));
        @(posedge clk); #1;
        exp_v = sb.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL reset_en0 got=%b exp=%b", got, exp_v);
        end
        @(negedge clk);
        bus.i_en = 1'b1;
        sb.push_back(mk(2, 2, 1, 0));
        @(posedge clk); #1;
        exp_v = sb.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL reset_first_en got=%b exp=%b", got, exp_v);
        end
    endtask

    task automatic test_manual();
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            bus.i_en   = 1'b1;
            bus.i_mode = 1'b0;
            bus.i_sel  = 2'(s);
            sb.push_back(mk(s, s, 1, 0));
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL manual_sel%0d got=%b exp=%b", s, got, exp_v);
            end
        end
    endtask

    task automatic test_auto_scan();
        int wraps = 0;
        @(negedge clk);
        bus.i_sel  = 2'd1;
        bus.i_mode = 1'b0;
        sb.push_back(mk(1, 1, 1, 0));
        @(posedge clk); #1;
        exp_v = sb.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL auto_preload got=%b exp=%b", got, exp_v);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.i_mode = 1'b1;
            sb.push_back(mk((1 + i / 4) % 4, (1 + i / 4) % 4, 1, i == 11));
            @(posedge clk); #1;
            if (bus.o_scan_wrap === 1'b1) wraps++;
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL auto_cyc%0d got=%b exp=%b", i, got, exp_v);
            end
        end
        checks++;
        if (wraps !== 1) begin
            errors++;
            $display("FAIL auto_wrap_count got=%0d exp=1", wraps);
        end
    endtask

    // Scan is at ch2 with dwell 0 on entry; show it twice, freeze 3 clocks, then resume.
    task automatic test_freeze();
        exp_t plan[8];
        plan[0] = mk(2, 2, 1, 0);
        plan[1] = mk(2, 2, 1, 0);
`ifdef MUX_SCAN_HOLD_EN
        plan[2] = mk(2, 2, 1, 0);
`else
        plan[2] = mk(0, 2, 0, 0);
`endif
        plan[3] = plan[2];
        plan[4] = plan[2];
        plan[5] = mk(2, 2, 1, 0);
        plan[6] = mk(2, 2, 1, 0);
        plan[7] = mk(3, 3, 1, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.i_mode = 1'b1;
            bus.i_en   = !(i >= 2 && i <= 4);
            sb.push_back(plan[i]);
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL freeze_cyc%0d got=%b exp=%b", i, got, exp_v);
            end
        end
    endtask

    // Mid-dwell drop to manual, restart scan from sel, and change din within a dwell.
    task automatic test_mode_switch();
        exp_t plan[6];
        plan[0] = mk(0, 0, 1, 0);
        plan[1] = mk(0, 0, 1, 0);
        plan[2] = mk(0, 0, 1, 0);
        plan[3] = mk(3, 0, 1, 0);
        plan[4] = mk(3, 0, 1, 0);
        plan[5] = mk(1, 1, 1, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.i_en   = 1'b1;
            bus.i_sel  = 2'd0;
            bus.i_mode = (i != 0);
            bus.i_din  = (i == 3 || i == 4) ? 8'b11_10_01_11 : DIN_DEF;
            sb.push_back(plan[i]);
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL mode_switch_cyc%0d got=%b exp=%b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.i_sel  = 2'd2;
        bus.i_mode = 1'b1;
        bus.i_en   = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (got !== mk(0, 0, 0, 0)) begin
            errors++;
            $display("FAIL async_reset_immediate got=%b exp=%b", got, mk(0, 0, 0, 0));
        end
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            sb.push_back(mk(i / 4, i / 4, 1, 0));
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL async_resume_cyc%0d got=%b exp=%b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_disable_hold();
        exp_t plan[3];
        plan[0] = mk(3, 3, 1, 0);
`ifdef MUX_SCAN_HOLD_EN
        plan[1] = mk(3, 3, 1, 0);
`else
        plan[1] = mk(0, 3, 0, 0);
`endif
        plan[2] = plan[1];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.i_mode = 1'b0;
            bus.i_sel  = 2'd3;
            bus.i_en   = (i == 0);
            sb.push_back(plan[i]);
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL disable_cyc%0d got=%b exp=%b", i, got, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_auto_scan();
        test_freeze();
        test_mode_switch();
        test_async_reset();
        test_disable_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_scan_reg.md
Name: mux_scan_reg

Overview:
- Parametrised, registered successor to the team's 4:1 2-bit enable mux.
- Selects one of CH channels of W-bit data onto a registered output.
- Two modes:
  - Manual: channel chosen by sel.
  - Auto-scan: channels cycled round-robin, each held for DWELL clocks.
- Sits between data sources and display/LED logic in lab designs; provides scanned multiplexing without external counters.

Parameters:
- W, 2, data width per channel.
- CH, 4, number of channels (2..16).
- SW, 2, select/index width; must satisfy 2^SW >= CH.
- DWELL, 4, clocks each channel is held in auto-scan mode (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- din  input  CH*W  packed channel data; channel k occupies bits [k*W+W-1 : k*W].
- sel  input  SW  manual channel select.
- en  input  1  enable; 0 blanks output and freezes scan.
- mode  input  1  0 = manual, 1 = auto-scan.
- y  output  W  registered selected data.
- y_ch  output  SW  channel index that produced y.
- y_valid  output  1  y holds valid channel data.
- scan_wrap  output  1  one-cycle pulse when scan index wraps CH-1 -> 0.

Behaviour:
- Reset (async, any time, including mid-scan): y=0, y_ch=0, y_valid=0, scan_wrap=0, internal scan_idx=0, dwell_cnt=0. First update on first rising edge after rst deasserts.
- All outputs registered. Latency is 1 clock from din/sel/en/mode to y/y_ch/y_valid.
- en=0:
  - y<=0, y_valid<=0, scan_wrap<=0.
  - y_ch, scan_idx, dwell_cnt hold.
- en=1, mode=0 (manual):
  - sel < CH: y<=din[sel], y_ch<=sel, y_valid<=1.
  - sel >= CH (CH not power of 2): y<=0, y_valid<=0, y_ch holds.
  - Each cycle: scan_idx<=(sel<CH ? sel : 0), dwell_cnt<=0. Auto-scan therefore starts from the manually selected channel.
- en=1, mode=1 (auto-scan):
  - y<=din[scan_idx], y_ch<=scan_idx, y_valid<=1.
  - dwell_cnt<DWELL-1: dwell_cnt increments.
  - dwell_cnt==DWELL-1: dwell_cnt<=0, scan_idx<=(scan_idx==CH-1) ? 0 : scan_idx+1.
  - scan_wrap<=1 on the edge where scan_idx goes CH-1 -> 0; otherwise 0.
  - Each channel appears on y for exactly DWELL consecutive cycles. Full period is CH*DWELL cycles.
- DWELL=1: index advances every clock.
- mode 1->0 mid-dwell: takes effect next edge, manual rule applies, scan state reloads from sel.
- mode 0->1: first auto-scan output is channel sel, held DWELL cycles.
- en 0->1 in auto mode: resumes at the frozen scan_idx/dwell_cnt. No restart.
- din changes mid-dwell: y follows the new data of the current channel on the next edge.

Optional Feature:
- Macro MUX_SCAN_HOLD_EN.
- Defined: en=0 holds y and y_valid at their previous values instead of forcing 0/0. scan_wrap still forced 0.
- Undefined: en=0 blanks (y=0, y_valid=0) as above.
- All other behaviour identical.

Test Plan:
- Defaults, din={11,10,01,00} (ch0=00..ch3=11). Reset, en=0, mode=0, sel=2 -> y=00, y_valid=0. Then en=1 -> next edge y=10, y_ch=2, y_valid=1.
- Manual sweep: en=1, sel=0,1,2,3 on successive cycles -> y=00,01,10,11, each one cycle later, y_valid=1 throughout.
- Auto-scan: sel=1, then mode=1, en=1 for 20 cycles:
  - y sequence is 01 x4, 10 x4, 11 x4, 00 x4, 01 x4.
  - scan_wrap pulses once, on the cycle the scan index goes 3->0.
- Freeze: in auto mode, drop en for 3 cycles mid-dwell (2 of 4 done on ch2) -> y=0, y_valid=0. On re-enable, ch2 shown 2 more cycles, then ch3.
- Async reset mid-scan: assert rst between edges -> y=0, y_ch=0, y_valid=0 immediately. After release in auto mode, scan starts at ch0.
- Build with MUX_SCAN_HOLD_EN, manual sel=3, then en=0 -> y stays 11, y_valid stays 1. Build without it -> y=00, y_valid=0.
